weight_load_ctrl: RTL and testbench

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_load_ctrl.sv | 133 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: gathers a serial stream of signed weights into KK-entry kernels and writes
// NUM_FEATURES kernels to feature memory. Define WLOAD_SAT_EN to clamp -2 to -1 and expose sat_flag.
module weight_load_ctrl #(
   parameter int KERNEL_SIZE  = 3,
   parameter int NUM_FEATURES = 10,
   parameter int DATA_W       = 2,
   localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
   localparam int AW = $clog2(NUM_FEATURES) + 1,
   localparam int BW = (KK > 1) ? $clog2(KK) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     w_valid,
   input  logic signed [DATA_W-1:0] w_data,
   output logic                     w_ready,
   output logic [AW-1:0]            address_w,
   output logic                     feature_WrEn,
   output logic signed [DATA_W-1:0] weights_input [KK],
   output logic                     busy,
   output logic                     done
`ifdef WLOAD_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [BW-1:0] LAST_BEAT = BW'(KK - 1);
   localparam logic [AW-1:0] LAST_FEAT = AW'(NUM_FEATURES - 1);

`ifdef WLOAD_SAT_EN
   localparam logic signed [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] W_SAT = {W_MIN[DATA_W-1:1], 1'b1};
`endif

   state_t        state, state_nx;
   logic [AW-1:0] feat_idx;
   logic [BW-1:0] beat_idx;
   logic          vld_p0;
   logic          last_beat;

   function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [DATA_W-1:0] d);
`ifdef WLOAD_SAT_EN
      return (d == W_MIN) ? W_SAT : d;
`else
      return d;
`endif
   endfunction

   assign vld_p0    = w_valid && w_ready;
   assign last_beat = (beat_idx == LAST_BEAT);

   always_comb begin
      state_nx     = state;
      w_ready      = 1'b0;
      feature_WrEn = 1'b1;
      busy         = 1'b1;
      done         = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = COLLECT;
         end
         COLLECT: begin
            w_ready = 1'b1;
            if (w_valid && last_beat) state_nx = WRITE;
         end
         WRITE: begin
            feature_WrEn = 1'b0;
            state_nx     = (feat_idx == LAST_FEAT) ? DONE : COLLECT;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // stage p0: beat capture, index bookkeeping and write-address latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         feat_idx  <= '0;
         beat_idx  <= '0;
         address_w <= '0;
         for (int i = 0; i < KK; i++) weights_input[i] <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  feat_idx <= '0;
                  beat_idx <= '0;
                  for (int i = 0; i < KK; i++) weights_input[i] <= '0;
               end
            end
            COLLECT: begin
               if (vld_p0) begin
                  weights_input[beat_idx] <= sat_w(w_data);
                  if (last_beat) begin
                     beat_idx  <= '0;
                     // address is latched on entry to WRITE so it holds afterwards
                     address_w <= feat_idx;
                  end else begin
                     beat_idx <= beat_idx + BW'(1);
                  end
               end
            end
            WRITE: begin
               if (feat_idx != LAST_FEAT) feat_idx <= feat_idx + AW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef WLOAD_SAT_EN
   always_ff @(posedge clk) begin
      if (rst)                          sat_flag <= 1'b0;
      else if (state == IDLE && start)  sat_flag <= 1'b0;
      else if (vld_p0 && w_data == W_MIN) sat_flag <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl: full sessions, stalls, ignored start, mid-session reset,
// and the WLOAD_SAT_EN clamp when that macro is defined.
module tb_weight_load_ctrl;

   localparam int KK = 9;
   localparam int NF = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              w_valid;
   logic signed [1:0] w_data;
   logic              w_ready;
   logic [4:0]        address_w;
   logic              feature_WrEn;
   logic signed [1:0] weights_input [KK];
   logic              busy;
   logic              done;
`ifdef WLOAD_SAT_EN
   logic              sat_flag;
`endif

   int total = 0;
   int bad   = 0;
   int edges = 0;

   weight_load_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .w_valid      (w_valid),
      .w_data       (w_data),
      .w_ready      (w_ready),
      .address_w    (address_w),
      .feature_WrEn (feature_WrEn),
      .weights_input(weights_input),
      .busy         (busy),
`ifdef WLOAD_SAT_EN
      .done         (done),
      .sat_flag     (sat_flag)
`else
      .done         (done)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   // mode 0: global stream 1,0,-1,...; mode 1: ((f+b)%3)-1; mode 2: mode 1 with -2 at f2 b4
   function automatic logic signed [1:0] stim(input int f, input int b, input int m);
      int v;
      if (m == 0) begin
         case ((f * KK + b) % 3)
            0:       v = 1;
            1:       v = 0;
            default: v = -1;
         endcase
      end else if (m == 2 && f == 2 && b == 4) begin
         v = -2;
      end else begin
         v = ((f + b) % 3) - 1;
      end
      return 2'(v);
   endfunction

   function automatic int expv(input int f, input int b, input int m);
      if (m == 2 && f == 2 && b == 4) return -1;
      return int'(stim(f, b, m));
   endfunction

   task automatic load_kernel(input int f, input int m, input bit toggle, input int start_b);
      for (int b = 0; b < KK; b++) begin
         if (toggle) begin
            w_valid = 1'b0;
            w_data  = -2'sd2;
            step();
            chk("stall_wren", feature_WrEn, 1);
            chk("stall_ready", w_ready, 1);
         end
         w_valid = 1'b1;
         w_data  = stim(f, b, m);
         start   = (b == start_b);
         step();
         start = 1'b0;
         if (b == 0 && f > 0) chk("addr_hold", address_w, f - 1);
         if (b < KK - 1) begin
            chk("collect_wren", feature_WrEn, 1);
            chk("collect_ready", w_ready, 1);
         end
      end
      // WRITE cycle: offer a beat that must not be taken
      w_valid = 1'b1;
      w_data  = -2'sd2;
      chk("write_wren", feature_WrEn, 0);
      chk("write_addr", address_w, f);
      chk("write_ready", w_ready, 0);
      chk("write_busy", busy, 1);
      for (int i = 0; i < KK; i++) chk("kernel", weights_input[i], expv(f, i, m));
      step();
      chk("post_write_wren", feature_WrEn, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ready", w_ready, 0);
      chk("rst_wren", feature_WrEn, 1);
      chk("rst_done", done, 0);
      chk("rst_addr", address_w, 0);
      for (int i = 0; i < KK; i++) chk("rst_weights", weights_input[i], 0);
`ifdef WLOAD_SAT_EN
      chk("rst_sat", sat_flag, 0);
`endif

      // reset wins over start
      start = 1'b1;
      step();
      chk("rst_start_busy", busy, 0);
      rst = 1'b0; start = 1'b0;
      step();
      chk("rst_start_idle", busy, 0);
      chk("rst_start_ready", w_ready, 0);

      // session A: 90 back-to-back beats
      edges = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("a_busy", busy, 1);
      chk("a_ready", w_ready, 1);
      for (int f = 0; f < NF; f++) load_kernel(f, 0, 1'b0, -1);
      w_valid = 1'b0;
      chk("a_done", done, 1);
      chk("a_done_busy", busy, 1);
      chk("a_latency", edges, 1 + NF * (KK + 1));
      step();
      chk("a_done_pulse", done, 0);
      chk("a_idle_busy", busy, 0);
      chk("a_addr_hold", address_w, 9);
      chk("a_idle_wren", feature_WrEn, 1);

      // session B: stalled kernel 0, start re-pulsed during feature 4
      start = 1'b1;
      step();
      start = 1'b0;
      for (int f = 0; f < NF; f++) load_kernel(f, 1, f == 0, (f == 4) ? 3 : -1);
      w_valid = 1'b0;
      chk("b_done", done, 1);
      step();
      chk("b_idle", busy, 0);

      // session C: reset during feature 3 beat 5
      start = 1'b1;
      step();
      start = 1'b0;
      for (int f = 0; f < 3; f++) load_kernel(f, 1, 1'b0, -1);
      for (int b = 0; b < 5; b++) begin
         w_valid = 1'b1;
         w_data  = stim(3, b, 1);
         step();
      end
      rst = 1'b1; start = 1'b1; w_valid = 1'b1; w_data = stim(3, 5, 1);
      step();
      rst = 1'b0; start = 1'b0;
      chk("c_busy", busy, 0);
      chk("c_ready", w_ready, 0);
      chk("c_wren", feature_WrEn, 1);
      chk("c_done", done, 0);
      chk("c_addr", address_w, 0);
      for (int i = 0; i < KK; i++) chk("c_weights", weights_input[i], 0);
      for (int k = 0; k < 12; k++) begin
         step();
         chk("c_quiet_wren", feature_WrEn, 1);
         chk("c_quiet_busy", busy, 0);
      end
      w_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      load_kernel(0, 0, 1'b0, -1);
      w_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;

`ifdef WLOAD_SAT_EN
      // session D: -2 in feature 2 clamps to -1 and sets the sticky flag
      start = 1'b1;
      step();
      start = 1'b0;
      chk("d_sat_start", sat_flag, 0);
      for (int f = 0; f < NF; f++) begin
         load_kernel(f, 2, 1'b0, -1);
         chk("d_sat", sat_flag, (f >= 2) ? 1 : 0);
      end
      w_valid = 1'b0;
      chk("d_done", done, 1);
      chk("d_sat_done", sat_flag, 1);
      step();
      chk("d_sat_idle", sat_flag, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("d_sat_clear", sat_flag, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
